// File: rtl/rv32i_mmu_pkg.sv
// Shared definitions for the rv32i memory-map unit: default region bases,
// MMIO register offsets and the region-select type.
package mmu_defines;

    localparam logic [31:0] DEF_TEXT_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_DATA_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hF000_0000;
    localparam logic [31:0] MMIO_BYTES    = 32'd64;

    localparam logic [5:0] MMIO_LEDS       = 6'h00;
    localparam logic [5:0] MMIO_BUTTONS    = 6'h04;
    localparam logic [5:0] MMIO_CYCLE      = 6'h08;
    localparam logic [5:0] MMIO_TIMER_CMP  = 6'h0C;
    localparam logic [5:0] MMIO_IRQ_STATUS = 6'h10;
    localparam logic [5:0] MMIO_ERR_ADDR   = 6'h14;

    typedef enum logic [1:0] {
        REGION_TEXT,
        REGION_DATA,
        REGION_MMIO,
        REGION_NONE
    } region_t;

endpackage

// File: rtl/rv32i_mmu_if.sv
// Core-side memory bus of the rv32i memory-map unit.
interface rv32i_mmu_if;
    // No handshake: the master holds addr every cycle and sees rd_data in the
    // same cycle; a write happens at the next posedge when wr_ena and ena are 1.
    logic        ena;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    logic [31:0] rd_data;

    modport master (output ena, output addr, output wr_data, output wr_ena, input rd_data);
    modport slave  (input ena, input addr, input wr_data, input wr_ena, output rd_data);
endinterface

// File: rtl/rv32i_mmu_word_ram.sv
// Word-wide RAM with asynchronous read and synchronous write; a read of the
// word being written returns the old contents until the clock edge.
module mmu_word_ram #(
    parameter int L2_WORDS = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [L2_WORDS-1:0] addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data
);

    logic [31:0] mem [2**L2_WORDS];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/rv32i_mmu.sv
// rv32i memory-map unit: text RAM, data RAM and an MMIO page (LEDs, buttons,
// cycle timer with compare irq). Optional MMU_BUS_ERROR_EN adds bus_error/ERR_ADDR.
module rv32i_mmu
    import mmu_defines::*;
#(
    parameter logic [31:0] TEXT_BASE     = DEF_TEXT_BASE,
    parameter int          TEXT_L2_WORDS = 10,
    parameter logic [31:0] DATA_BASE     = DEF_DATA_BASE,
    parameter int          DATA_L2_WORDS = 10,
    parameter logic [31:0] MMIO_BASE     = DEF_MMIO_BASE,
    parameter bit          TEXT_WRITABLE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    rv32i_mmu_if.slave    bus,
    output logic [7:0]    leds,
    input  logic [3:0]    buttons,
    output logic          irq,
    output logic          bus_error
);

    localparam logic [31:0] TEXT_BYTES = 32'd4 << TEXT_L2_WORDS;
    localparam logic [31:0] DATA_BYTES = 32'd4 << DATA_L2_WORDS;

    logic [31:0] text_off, data_off, mmio_off;
    region_t     region;
    logic [5:0]  mmio_reg;
    logic [31:0] text_rd, data_rd;
    logic [31:0] mmio_rd;
    logic        text_we, data_we, mmio_wr;

    logic [3:0]  btn_meta, btn_sync;
    logic [31:0] cycle, timer_cmp;
    logic        irq_set, irq_clr;

    // Offset-relative compares keep each range check a single unsigned compare.
    assign text_off = bus.addr - TEXT_BASE;
    assign data_off = bus.addr - DATA_BASE;
    assign mmio_off = bus.addr - MMIO_BASE;
    assign mmio_reg = {mmio_off[5:2], 2'b00};

    always_comb begin
        region = REGION_NONE;
        if (text_off < TEXT_BYTES) begin
            region = REGION_TEXT;
        end else if (data_off < DATA_BYTES) begin
            region = REGION_DATA;
        end else if (mmio_off < MMIO_BYTES) begin
            region = REGION_MMIO;
        end
    end

    assign text_we = bus.ena && bus.wr_ena && (region == REGION_TEXT) && TEXT_WRITABLE;
    assign data_we = bus.ena && bus.wr_ena && (region == REGION_DATA);
    assign mmio_wr = bus.ena && bus.wr_ena && (region == REGION_MMIO);

    mmu_word_ram #(.L2_WORDS(TEXT_L2_WORDS)) u_text_ram (
        .clk     (clk),
        .we      (text_we),
        .addr    (text_off[TEXT_L2_WORDS+1:2]),
        .wr_data (bus.wr_data),
        .rd_data (text_rd)
    );

    mmu_word_ram #(.L2_WORDS(DATA_L2_WORDS)) u_data_ram (
        .clk     (clk),
        .we      (data_we),
        .addr    (data_off[DATA_L2_WORDS+1:2]),
        .wr_data (bus.wr_data),
        .rd_data (data_rd)
    );

    assign irq_set = bus.ena && (timer_cmp != 32'd0) && (cycle == timer_cmp);
    assign irq_clr = mmio_wr && (mmio_reg == MMIO_IRQ_STATUS) && bus.wr_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            leds      <= 8'd0;
            btn_meta  <= 4'd0;
            btn_sync  <= 4'd0;
            cycle     <= 32'd0;
            timer_cmp <= 32'd0;
            irq       <= 1'b0;
        end else if (bus.ena) begin
            btn_meta <= buttons;
            btn_sync <= btn_meta;
            if (mmio_wr && (mmio_reg == MMIO_CYCLE)) begin
                cycle <= bus.wr_data;
            end else begin
                cycle <= cycle + 32'd1;
            end
            if (mmio_wr && (mmio_reg == MMIO_LEDS)) begin
                leds <= bus.wr_data[7:0];
            end
            if (mmio_wr && (mmio_reg == MMIO_TIMER_CMP)) begin
                timer_cmp <= bus.wr_data;
            end
            // A compare match in the same cycle as a W1C clear keeps irq set.
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef MMU_BUS_ERROR_EN
    logic [31:0] err_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_error <= 1'b0;
            err_addr  <= 32'd0;
        end else if (bus.ena) begin
            if (mmio_wr && (mmio_reg == MMIO_ERR_ADDR)) begin
                bus_error <= 1'b0;
                err_addr  <= 32'd0;
            end else if (region == REGION_NONE) begin
                bus_error <= 1'b1;
                if (!bus_error) begin
                    err_addr <= bus.addr;
                end
            end
        end
    end
`else
    assign bus_error = 1'b0;
`endif

    always_comb begin
        mmio_rd = 32'd0;
        case (mmio_reg)
            MMIO_LEDS:       mmio_rd = {24'd0, leds};
            MMIO_BUTTONS:    mmio_rd = {28'd0, btn_sync};
            MMIO_CYCLE:      mmio_rd = cycle;
            MMIO_TIMER_CMP:  mmio_rd = timer_cmp;
            MMIO_IRQ_STATUS: mmio_rd = {31'd0, irq};
`ifdef MMU_BUS_ERROR_EN
            MMIO_ERR_ADDR:   mmio_rd = err_addr;
`endif
            default:         mmio_rd = 32'd0;
        endcase
    end

    always_comb begin
        bus.rd_data = 32'd0;
        case (region)
            REGION_TEXT: bus.rd_data = text_rd;
            REGION_DATA: bus.rd_data = data_rd;
            REGION_MMIO: bus.rd_data = mmio_rd;
            default:     bus.rd_data = 32'd0;
        endcase
    end

endmodule

// File: doc/rv32i_mmu.md
Name: rv32i_mmu

Overview:
Memory-map unit directly downstream of the multicycle core's memory interface (address, write data, write enable, read data).
- Decodes each word address into one of three regions: instruction RAM (text), data RAM, or the MMIO register page.
- Performs the access in that region and returns read data combinationally, so the core can capture it in the same cycle it drives the address.
- Owns the board-facing LED and button I/O plus a free-running cycle counter with a compare interrupt.

Parameters:
TEXT_BASE, 32'h0000_0000, byte base address of the instruction RAM.
TEXT_L2_WORDS, 10, log2 of the instruction RAM depth in 32-bit words.
DATA_BASE, 32'h1000_0000, byte base address of the data RAM.
DATA_L2_WORDS, 10, log2 of the data RAM depth in 32-bit words.
MMIO_BASE, 32'hF000_0000, byte base address of the MMIO page (64 bytes).
TEXT_WRITABLE, 1, 1 = text RAM accepts writes (used for program loading); 0 = text writes are silently dropped.

Ports:
clk  in  1  clock
rst  in  1  reset
ena  in  1  global enable; when 0, no state updates occur
addr  in  32  byte address from the core; addr[1:0] ignored (word accesses only)
wr_data  in  32  write data
wr_ena  in  1  write strobe, sampled at posedge clk
rd_data  out  32  read data, combinational from addr and current state
leds  out  8  LED register
buttons  in  4  asynchronous push-button inputs
irq  out  1  timer interrupt pending (level)
bus_error  out  1  sticky unmapped-access flag (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset clears: leds=0, cycle=0, timer_cmp=0, irq=0, button synchronizer=0, bus_error=0, err_addr=0.
  - RAM contents are not reset.
- Decode: a region hit means addr lies in [BASE, BASE + 4·2^L2_WORDS). The word index is addr[L2+1:2] taken relative to the region base. At most one region hits.
- Reads: zero-latency combinational.
  - Unmapped addresses, and unused MMIO offsets, read 32'h0.
- Writes: take effect at posedge when wr_ena && ena && a region hit.
  - Writes to unmapped addresses are dropped.
  - Read-during-write to the same word returns the old value within that cycle.
- MMIO offsets (byte offset from MMIO_BASE):
  - 0x00 LEDS: R/W, bits [7:0]; upper bits read 0.
  - 0x04 BUTTONS: read-only, 2-flop synchronized value in bits [3:0]; value appears 2 cycles after an input change.
  - 0x08 CYCLE: R/W. Increments by 1 every cycle while ena=1 and wraps 32'hFFFF_FFFF→0. A software write loads wr_data and takes priority over the increment in that cycle.
  - 0x0C TIMER_CMP: R/W.
  - 0x10 IRQ_STATUS: bit0 = irq. Writing 1 to bit0 clears it (W1C); writing 0 has no effect.
  - 0x14 ERR_ADDR: read-only; present only with the optional feature, otherwise reads 0.
- Interrupt: irq is set the cycle after cycle == timer_cmp with timer_cmp != 0 and ena=1.
  - If a set and a W1C clear occur in the same cycle, the set wins.
  - irq stays high until cleared.
- ena=0: the counter holds, writes are ignored, irq holds. Reads still operate.
- Reset mid-operation: an in-flight write in the reset cycle to an MMIO register is discarded. An in-flight RAM write in that cycle may still complete.

Optional Feature:
MMU_BUS_ERROR_EN
- Defined:
  - Any access to an unmapped address sets bus_error (sticky until rst). An access is a write with wr_ena, or a read, i.e. any cycle with ena=1.
  - The first offending addr is latched into ERR_ADDR. Later errors do not overwrite it.
  - Writing any value to ERR_ADDR clears both bus_error and ERR_ADDR.
- Undefined: bus_error is tied 0, no ERR_ADDR register exists, and offset 0x14 reads 0.

Decomposition:
- Package mmu_defines holds:
  - default base addresses;
  - the MMIO offset constants (MMIO_LEDS, MMIO_BUTTONS, MMIO_CYCLE, MMIO_TIMER_CMP, MMIO_IRQ_STATUS, MMIO_ERR_ADDR);
  - the region-select enum {REGION_TEXT, REGION_DATA, REGION_MMIO, REGION_NONE}.
- One sub-module, mmu_word_ram: parameter L2_WORDS; asynchronous read, synchronous write. Instantiated twice (text and data).

Test Plan:
- Write 32'hDEADBEEF to 0x1000_0004, then read 0x1000_0004 → 32'hDEADBEEF. Read 0x1000_0007 → same word.
- Write 32'hA5 to 0xF000_0000 → leds=8'hA5 next cycle. Read 0xF000_0000 → 32'h0000_00A5.
- Drive buttons=4'b1010 → BUTTONS reads 0 for 2 cycles, then 32'hA.
- Write CYCLE=32'hFFFF_FFFE, then hold ena=1 → reads FFFF_FFFF, then 0, then 1.
- Write TIMER_CMP=20 → irq rises the cycle after cycle==20. Write 1 to IRQ_STATUS → irq=0 next cycle. Clear issued in the same cycle as the match → irq stays 1.
- With MMU_BUS_ERROR_EN: read 0x2000_0000 → rd_data=0, bus_error=1, ERR_ADDR=32'h2000_0000. A second bad access to 0x3000_0000 leaves ERR_ADDR unchanged. Write to ERR_ADDR → bus_error=0.
